// File: rtl/keccak_round_sequencer.sv
// Keccak-f round controller: walks theta/rho/pi/chi/iota over the requested
// number of rounds, issuing one go/done handshake per step iteration, with a
// step-enable mask, abort and a watchdog on the unit_done response.
module keccak_round_sequencer #(
  parameter int W       = 64,
  parameter int WLOG    = 6,
  parameter int NROUNDS = 24,
  parameter int TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      rounds_in,
  input  logic [4:0]      step_mask,
  input  logic            abort,
  input  logic            unit_done,
  output logic            step_go,
  output logic [2:0]      step_sel,
  output logic [WLOG-1:0] idx,
  output logic [4:0]      round_idx,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, FIN, ERR} state_t;

  state_t          state, stateNxt;
  logic [2:0]      selNxt;
  logic [WLOG-1:0] idxNxt;
  logic [4:0]      roundNxt;
  logic [4:0]      nr, nrNxt;
  logic [4:0]      mask, maskNxt;
  logic [9:0]      wdog, wdogNxt;
  logic            errNxt;
  logic            found;
  logic [2:0]      firstSel;

  // Zero or out-of-range round requests run the full permutation.
  function automatic logic [4:0] clampRounds(input logic [4:0] r);
    if (r == 5'd0 || r > 5'(NROUNDS)) return 5'(NROUNDS);
    return r;
  endfunction

  // Final iteration index of each step: slices for theta/chi, lanes for rho,
  // a single pass for pi and iota.
  function automatic logic isLast(input logic [2:0] sel, input logic [WLOG-1:0] i);
    case (sel)
      3'd0, 3'd3: return i == WLOG'(W - 1);
      3'd1:       return i == WLOG'(24);
      default:    return i == '0;
    endcase
  endfunction

  // Find the first enabled step at or above the current selection, so skipped
  // steps cost no cycle.
  always_comb begin
    found    = 1'b0;
    firstSel = 3'd0;
    for (int s = 4; s >= 0; s--) begin
      if (3'(s) >= step_sel && mask[s]) begin
        found    = 1'b1;
        firstSel = 3'(s);
      end
    end
  end

  // Next-state and register-update logic; abort outranks everything outside IDLE.
  always_comb begin
    stateNxt = state;
    selNxt   = step_sel;
    idxNxt   = idx;
    roundNxt = round_idx;
    nrNxt    = nr;
    maskNxt  = mask;
    wdogNxt  = wdog;
    errNxt   = err;
    if (abort && state != IDLE) begin
      stateNxt = IDLE;
    end else begin
      case (state)
        IDLE, ERR: begin
          if (start) begin
            nrNxt    = clampRounds(rounds_in);
            maskNxt  = step_mask;
            roundNxt = 5'd0;
            selNxt   = 3'd0;
            idxNxt   = '0;
            errNxt   = 1'b0;
            stateNxt = NEXT;
          end
        end
        NEXT: begin
          if (found) begin
            selNxt   = firstSel;
            idxNxt   = '0;
            stateNxt = ISSUE;
          end else if (round_idx == nr - 5'd1) begin
            stateNxt = FIN;
          end else begin
            roundNxt = round_idx + 5'd1;
            selNxt   = 3'd0;
          end
        end
        ISSUE: begin
          wdogNxt  = 10'd0;
          stateNxt = WAIT;
        end
        WAIT: begin
          if (unit_done) begin
            if (isLast(step_sel, idx)) begin
              selNxt   = step_sel + 3'd1;
              stateNxt = NEXT;
            end else begin
              idxNxt   = idx + 1'b1;
              stateNxt = ISSUE;
            end
          end else if (wdog == 10'(TIMEOUT - 1)) begin
            errNxt   = 1'b1;
            stateNxt = ERR;
          end else begin
            wdogNxt = wdog + 10'd1;
          end
        end
        FIN:     stateNxt = IDLE;
        default: stateNxt = IDLE;
      endcase
    end
  end

  // State and bookkeeping registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      step_sel  <= 3'd0;
      idx       <= '0;
      round_idx <= 5'd0;
      nr        <= 5'd0;
      mask      <= 5'd0;
      wdog      <= 10'd0;
      err       <= 1'b0;
    end else begin
      state     <= stateNxt;
      step_sel  <= selNxt;
      idx       <= idxNxt;
      round_idx <= roundNxt;
      nr        <= nrNxt;
      mask      <= maskNxt;
      wdog      <= wdogNxt;
      err       <= errNxt;
    end
  end

  assign step_go = (state == ISSUE);
  assign done    = (state == FIN);
  assign busy    = (state == ISSUE) || (state == WAIT) || (state == NEXT);

endmodule

// File: tb/tb_keccak_round_sequencer.sv
// Directed bench for keccak_round_sequencer: a unit_done responder answers
// each step_go one cycle later, and each scenario checks pulse counts,
// iteration order, completion timing, watchdog and abort behaviour.
module tb_keccak_round_sequencer;
  localparam int W       = 64;
  localparam int WLOG    = 6;
  localparam int NROUNDS = 24;
  localparam int TIMEOUT = 1023;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [4:0]      rounds_in;
  logic [4:0]      step_mask;
  logic            abort;
  logic            unit_done;
  logic            step_go;
  logic [2:0]      step_sel;
  logic [WLOG-1:0] idx;
  logic [4:0]      round_idx;
  logic            busy;
  logic            done;
  logic            err;

  keccak_round_sequencer #(.W(W), .WLOG(WLOG), .NROUNDS(NROUNDS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .rounds_in(rounds_in), .step_mask(step_mask),
    .abort(abort), .unit_done(unit_done), .step_go(step_go), .step_sel(step_sel),
    .idx(idx), .round_idx(round_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int passCnt = 0;
  int totalCnt = 0;

  int goCnt[5];
  int doneCnt, roundAtDone, doneCycle, errCycle, stallCycle, idxErr, cyc, goAfterStop;
  int stopSel, stopIdx, midStartCyc, lastSel, lastRound, expIdx;
  bit prevGo, stopped, stopIsAbort, finished;
  logic [2:0] seq[$];

  task automatic clearStats();
    for (int i = 0; i < 5; i++) goCnt[i] = 0;
    doneCnt = 0; roundAtDone = -1; doneCycle = -1; errCycle = -1; stallCycle = -1;
    idxErr = 0; goAfterStop = 0; stopped = 0; stopSel = -1; stopIdx = -1;
    stopIsAbort = 0; midStartCyc = -1; lastSel = -1; lastRound = -1; expIdx = 0;
    seq.delete(); prevGo = 0; finished = 0;
  endtask

  task automatic doStart(input logic [4:0] r, input logic [4:0] m);
    @(negedge clk);
    unit_done = 1'b0;
    abort     = 1'b0;
    rounds_in = r;
    step_mask = m;
    start     = 1'b1;
    prevGo    = 1'b0;
  endtask

  // Observe one cycle per falling edge, answer step_go, track iteration order.
  task automatic runLoop(input int maxCyc, input int extraAfterStop);
    cyc = 0;
    finished = 0;
    while (!finished && cyc < maxCyc) begin
      @(negedge clk);
      cyc++;
      start = (cyc == midStartCyc);
      if (cyc == midStartCyc) begin
        rounds_in = 5'd1;
        step_mask = 5'd0;
      end
      abort = 1'b0;
      if (step_go) begin
        if (stopped) goAfterStop++;
        else begin
          if (step_sel < 3'd5) goCnt[step_sel]++;
          if (int'(step_sel) != lastSel || int'(round_idx) != lastRound) begin
            expIdx = 0;
            if (int'(step_sel) != lastSel) seq.push_back(step_sel);
          end
          if (int'(idx) != expIdx) idxErr++;
          expIdx++;
          lastSel   = int'(step_sel);
          lastRound = int'(round_idx);
          if (int'(step_sel) == stopSel && int'(idx) == stopIdx) begin
            stopped    = 1'b1;
            stallCycle = cyc;
          end
        end
      end
      if (done) begin
        doneCnt++;
        roundAtDone = int'(round_idx);
        doneCycle   = cyc;
      end
      if (err && errCycle < 0) errCycle = cyc;
      if (stopped && stopIsAbort && cyc == stallCycle + 1) abort = 1'b1;
      unit_done = prevGo && !(stopped && !stopIsAbort);
      prevGo    = step_go;
      if (done || err || (stopped && stopIsAbort && cyc >= stallCycle + extraAfterStop))
        finished = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; unit_done = 1'b0;
    rounds_in = 5'd0; step_mask = 5'd0;
    repeat (3) @(negedge clk);
    totalCnt++;
    if ({step_go, busy, done, err} !== 4'b0000) $display("FAIL reset_ctrl: got %b expected 0000", {step_go, busy, done, err});
    else passCnt++;
    totalCnt++;
    if ({step_sel, idx, round_idx} !== '0) $display("FAIL reset_idx: sel=%0d idx=%0d round=%0d expected all 0", step_sel, idx, round_idx);
    else passCnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_run();
    clearStats();
    doStart(5'd24, 5'h1F);
    runLoop(10000, 0);
    totalCnt++;
    if (!finished) $display("FAIL full_timeout: got no done within budget, expected done");
    else passCnt++;
    totalCnt++;
    if (goCnt[0] + goCnt[1] + goCnt[2] + goCnt[3] + goCnt[4] !== 3720)
      $display("FAIL full_go_total: got %0d expected 3720", goCnt[0] + goCnt[1] + goCnt[2] + goCnt[3] + goCnt[4]);
    else passCnt++;
    totalCnt++;
    if (goCnt[1] !== 600) $display("FAIL full_rho_count: got %0d expected 600", goCnt[1]);
    else passCnt++;
    totalCnt++;
    if (goCnt[3] !== 1536) $display("FAIL full_chi_count: got %0d expected 1536", goCnt[3]);
    else passCnt++;
    totalCnt++;
    if (idxErr !== 0) $display("FAIL full_idx_order: got %0d bad indices expected 0", idxErr);
    else passCnt++;
    totalCnt++;
    if (roundAtDone !== 23) $display("FAIL full_round_at_done: got %0d expected 23", roundAtDone);
    else passCnt++;
    totalCnt++;
    if (doneCycle !== 7585) $display("FAIL full_done_cycle: got %0d expected 7585", doneCycle);
    else passCnt++;
    @(negedge clk);
    totalCnt++;
    if ({busy, done} !== 2'b00) $display("FAIL full_after_done: busy,done got %b expected 00", {busy, done});
    else passCnt++;
  endtask

  task automatic test_sparse_mask();
    int bad;
    logic [2:0] expSeq[6];
    expSeq = '{3'd0, 3'd2, 3'd4, 3'd0, 3'd2, 3'd4};
    clearStats();
    doStart(5'd2, 5'b10101);
    runLoop(1000, 0);
    totalCnt++;
    if ({goCnt[0], goCnt[1], goCnt[2], goCnt[3], goCnt[4]} !== {32'd128, 32'd0, 32'd2, 32'd0, 32'd2})
      $display("FAIL sparse_counts: got %0d,%0d,%0d,%0d,%0d expected 128,0,2,0,2",
               goCnt[0], goCnt[1], goCnt[2], goCnt[3], goCnt[4]);
    else passCnt++;
    bad = (seq.size() == 6) ? 0 : 1;
    if (seq.size() == 6) for (int i = 0; i < 6; i++) if (seq[i] !== expSeq[i]) bad++;
    totalCnt++;
    if (bad !== 0) $display("FAIL sparse_sequence: got %0d entries with %0d wrong expected 0,2,4,0,2,4", seq.size(), bad);
    else passCnt++;
    totalCnt++;
    if (idxErr !== 0) $display("FAIL sparse_idx_order: got %0d bad indices expected 0", idxErr);
    else passCnt++;
    totalCnt++;
    if ({doneCnt, roundAtDone, doneCycle} !== {32'd1, 32'd1, 32'd273})
      $display("FAIL sparse_done: count=%0d round=%0d cycle=%0d expected 1,1,273", doneCnt, roundAtDone, doneCycle);
    else passCnt++;
  endtask

  task automatic test_zero_mask();
    clearStats();
    doStart(5'd3, 5'd0);
    runLoop(50, 0);
    totalCnt++;
    if (goCnt[0] + goCnt[1] + goCnt[2] + goCnt[3] + goCnt[4] !== 0)
      $display("FAIL zero_mask_go: got %0d pulses expected 0", goCnt[0] + goCnt[1] + goCnt[2] + goCnt[3] + goCnt[4]);
    else passCnt++;
    totalCnt++;
    if ({doneCycle, roundAtDone} !== {32'd4, 32'd2})
      $display("FAIL zero_mask_done: cycle=%0d round=%0d expected 4,2", doneCycle, roundAtDone);
    else passCnt++;
  endtask

  task automatic test_clamp();
    logic [4:0] req[3];
    int expN[3];
    req  = '{5'd0, 5'd31, 5'd5};
    expN = '{24, 24, 5};
    for (int k = 0; k < 3; k++) begin
      clearStats();
      doStart(req[k], 5'b10000);
      runLoop(500, 0);
      totalCnt++;
      if (goCnt[4] !== expN[k] || roundAtDone !== expN[k] - 1)
        $display("FAIL clamp_rounds_%0d: iota=%0d last_round=%0d expected %0d,%0d",
                 req[k], goCnt[4], roundAtDone, expN[k], expN[k] - 1);
      else passCnt++;
    end
  endtask

  task automatic test_watchdog();
    clearStats();
    stopSel = 1; stopIdx = 7;
    doStart(5'd1, 5'h1F);
    runLoop(3000, 0);
    totalCnt++;
    if ({err, busy} !== 2'b10) $display("FAIL wdog_err: err,busy got %b expected 10", {err, busy});
    else passCnt++;
    totalCnt++;
    if (errCycle - stallCycle !== TIMEOUT + 1)
      $display("FAIL wdog_latency: got %0d cycles expected %0d", errCycle - stallCycle, TIMEOUT + 1);
    else passCnt++;
    totalCnt++;
    if ({goAfterStop, doneCnt} !== {32'd0, 32'd0})
      $display("FAIL wdog_quiet: go_after=%0d done=%0d expected 0,0", goAfterStop, doneCnt);
    else passCnt++;
    repeat (5) @(negedge clk);
    totalCnt++;
    if ({err, busy, step_go} !== 3'b100) $display("FAIL wdog_hold: err,busy,go got %b expected 100", {err, busy, step_go});
    else passCnt++;
    // restart from ERR
    clearStats();
    doStart(5'd1, 5'h1F);
    runLoop(2, 0);
    totalCnt++;
    if ({err, busy} !== 2'b01) $display("FAIL wdog_restart_err: err,busy got %b expected 01", {err, busy});
    else passCnt++;
    totalCnt++;
    if (goCnt[0] !== 1 || lastSel !== 0 || lastRound !== 0 || idxErr !== 0)
      $display("FAIL wdog_restart_first: theta=%0d sel=%0d round=%0d idx_err=%0d expected 1,0,0,0",
               goCnt[0], lastSel, lastRound, idxErr);
    else passCnt++;
    @(negedge clk);
    unit_done = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_abort();
    clearStats();
    stopSel = 3; stopIdx = 30; stopIsAbort = 1; midStartCyc = 50;
    doStart(5'd2, 5'h1F);
    runLoop(2000, 20);
    totalCnt++;
    if ({goCnt[0], goCnt[3], goCnt[4]} !== {32'd64, 32'd31, 32'd0})
      $display("FAIL abort_counts: theta=%0d chi=%0d iota=%0d expected 64,31,0", goCnt[0], goCnt[3], goCnt[4]);
    else passCnt++;
    totalCnt++;
    if ({goAfterStop, doneCnt, idxErr} !== {32'd0, 32'd0, 32'd0})
      $display("FAIL abort_quiet: go_after=%0d done=%0d idx_err=%0d expected 0,0,0", goAfterStop, doneCnt, idxErr);
    else passCnt++;
    totalCnt++;
    if ({busy, err, done} !== 3'b000) $display("FAIL abort_idle: busy,err,done got %b expected 000", {busy, err, done});
    else passCnt++;
  endtask

  task automatic test_async_reset();
    clearStats();
    doStart(5'd24, 5'h1F);
    runLoop(10, 0);
    #2 rst = 1'b1;
    #1;
    totalCnt++;
    if ({busy, step_go, step_sel, idx} !== '0)
      $display("FAIL async_reset: busy=%b go=%b sel=%0d idx=%0d expected all 0", busy, step_go, step_sel, idx);
    else passCnt++;
    unit_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_sparse_mask();
    test_zero_mask();
    test_clamp();
    test_watchdog();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/keccak_round_sequencer.md
Name: keccak_round_sequencer

Overview:
Parametrised Keccak-f round controller. It sequences the five step units (theta, rho, pi, chi, iota) over a configurable number of rounds and lane width. Each unit is driven through one generic go/done handshake, with per-step iteration indices, a step-enable mask, abort and a watchdog. It sits between the top-level start/done interface and the step datapaths, replacing hard-wired per-step counters.

Parameters:
- W, 64, lane width (slice count); power of two, 8..64.
- WLOG, 6, log2(W).
- NROUNDS, 24, maximum round count (12+2*WLOG).
- TIMEOUT, 1023, maximum cycles waiting for unit_done before error; 10-bit counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  begin permutation; sampled in IDLE or ERR only
- rounds_in  in  5  requested rounds; 0 or >NROUNDS clamps to NROUNDS
- step_mask  in  5  per-step enable {iota,chi,pi,rho,theta}, bit0=theta
- abort  in  1  synchronous cancel
- unit_done  in  1  selected unit finished current iteration
- step_go  out  1  one-cycle pulse, start one iteration of step_sel
- step_sel  out  3  0=theta,1=rho,2=pi,3=chi,4=iota
- idx  out  WLOG  iteration index: slice z for theta/chi, lane 0..24 for rho, 0 for pi/iota
- round_idx  out  5  current round, 0-based (iota RC select)
- busy  out  1  high outside IDLE/ERR
- done  out  1  one-cycle pulse at completion
- err  out  1  sticky watchdog error

Behaviour:
- Reset is rst, asynchronous, active-high, on clock clk. Reset forces state IDLE and clears step_go, step_sel, idx, round_idx, busy, done and err to 0.
- States: IDLE, ISSUE, WAIT, NEXT, FIN, ERR.
- IDLE, start=1: latch clamped rounds_in as nr and step_mask as mask. Set round_idx=0, step_sel=0, idx=0, clear err, go to NEXT. NEXT selects the first enabled step.
- NEXT (1 cycle): scan step_sel upward from current value to the first enabled step.
  - Enabled step found: go to ISSUE with idx=0.
  - No enabled step remains in the round: round_idx++ and step_sel=0.
  - If round_idx was nr-1: go to FIN instead.
  - Each skipped step costs no extra cycle. A mask of 0 costs 1 NEXT cycle per round.
- ISSUE: step_go=1 for exactly this cycle, watchdog cleared, go to WAIT.
- WAIT: unit_done sampled only here; unit_done in the ISSUE cycle is ignored.
  - On unit_done, last index reached (theta/chi idx=W-1; rho idx=24; pi/iota idx=0): step_sel++, go to NEXT.
  - On unit_done otherwise: idx++, go to ISSUE. Minimum 2 cycles per iteration.
- Watchdog: counts in WAIT. Reaching TIMEOUT without unit_done goes to ERR: err=1, busy=0. ERR holds until start (restart, err cleared) or rst.
- FIN: done=1 for one cycle, busy=0, go to IDLE. round_idx holds nr-1 until the next start.
- abort=1 in any state except IDLE: go to IDLE next cycle with step_go=0, done=0; err is unchanged. abort has priority over unit_done, the watchdog and start.
- start while busy is ignored. mask and nr changes mid-run are ignored (latched values are used).
- idx width WLOG holds 0..W-1. The rho limit of 24 requires W>=32: W<32 supports only masks with rho disabled, or WLOG must be raised to 5.
- Total cycles per round (enabled steps, unit_done one cycle after go): 2*(2W+25+1+1) + number of NEXT cycles.

Test Plan:
- W=64, rounds_in=24, mask=5'h1F, unit_done always 1 cycle after step_go → step_go count = 24*(64+25+1+64+1) = 3720. done pulses once; round_idx=23 at done; busy low the next cycle.
- rounds_in=2, mask=5'b10101 (theta, pi, iota) → step_sel sequence per round is 0 (64 pulses, idx 0..63), 2 (1 pulse), 4 (1 pulse). No rho/chi go. done after round_idx=1.
- mask=0, rounds_in=3 → no step_go; done asserted 4 cycles after start (3 NEXT + FIN).
- rounds_in=0 and rounds_in=31 → both run 24 rounds (iota pulses = 24).
- Hold unit_done low in rho at idx=7 → err=1, busy=0 after TIMEOUT cycles. A subsequent start clears err and restarts at round 0, theta idx 0.
- abort asserted mid-chi at idx=30 and coincident with unit_done → IDLE next cycle, no further step_go, done stays 0. A start during the run before the abort is ignored.
